// File: rtl/ysyx_25030093_axi_rd_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_25030093_axi_rd_arbiter_pkg
// Purpose : shared types and constants for the IFU/LSU AXI read arbiter.
//           Holds the arbiter FSM state enum, the AXI RESP codes and a small
//           32-bit select helper used when steering the granted master.
// Ports   : none (package).
// ----------------------------------------------------------------------------
package ysyx_25030093_axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Grant index 1'b1 selects the LSU (m1), 1'b0 selects the IFU (m0).
  function automatic logic [31:0] sel32(input logic sel, input logic [31:0] a0,
                                        input logic [31:0] a1);
    sel32 = sel ? a1 : a0;
  endfunction

endpackage

// File: rtl/ysyx_25030093_axi_rd_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// ysyx_25030093_rr_pick
// Purpose : two-way tie-break for the read arbiter.
// Ports   : req[1:0] - request vector (bit 0 = m0, bit 1 = m1)
//           last     - master granted by the previous completed transaction
//           rr_en    - 1: round-robin on ties, 0: m1 always wins ties
//           grant    - chosen master (0 = m0, 1 = m1); meaningless if req==0
// ----------------------------------------------------------------------------
module ysyx_25030093_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       grant
);

  // Pick the single requester, or resolve a tie by policy.
  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = rr_en ? ~last : 1'b1;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_25030093_axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_25030093_axi_rd_arbiter
// Purpose : arbitrates AXI read requests from the IFU (m0) and LSU (m1) onto
//           one downstream read port, one transaction outstanding at a time.
// Ports   : clock, reset_n           - clock, async active-low reset
//           m0_ar*/m0_r*             - IFU AR and R channels (slave side)
//           m1_ar*/m1_r*             - LSU AR and R channels (slave side)
//           s_ar*/s_r*               - downstream AR and R channels (master)
// Parameter RR_EN : 1 = round-robin on ties, 0 = m1 wins ties.
// ----------------------------------------------------------------------------
module ysyx_25030093_axi_rd_arbiter
  import ysyx_25030093_axi_rd_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  input  logic        m0_rready,
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  input  logic        m1_rready,
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  output logic        s_rready
);

  localparam logic RR_EN_L = (RR_EN != 0);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       pick_s;
  logic       mg_rready_s;

  ysyx_25030093_rr_pick u_pick (
    .req   ({m1_arvalid, m0_arvalid}),
    .last  (last_q),
    .rr_en (RR_EN_L),
    .grant (pick_s)
  );

  assign mg_rready_s = grant_q ? m1_rready : m0_rready;

  // Next-state: grant latched in IDLE, last_grant updated on R completion.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          grant_d = pick_s;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (s_arready) begin
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (s_rvalid && mg_rready_s) begin
          state_d = IDLE;
          last_d  = grant_q;
        end else begin
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset leaves last_grant at m1 so the first tie goes to m0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Output steering: only the granted master ever sees handshakes or data;
  // everything is zero in IDLE, which also covers the reset condition.
  always_comb begin
    s_araddr   = 32'd0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = 32'd0;
    m1_rdata   = 32'd0;
    m0_rresp   = RESP_OKAY;
    m1_rresp   = RESP_OKAY;
    case (state_q)
      IDLE: begin
        s_arvalid = 1'b0;
      end
      ADDR: begin
        s_arvalid = 1'b1;
        s_araddr  = sel32(grant_q, m0_araddr, m1_araddr);
        if (grant_q) begin
          m1_arready = s_arready;
        end else begin
          m0_arready = s_arready;
        end
      end
      DATA: begin
        s_rready = mg_rready_s;
        if (grant_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
      end
      default: begin
        s_arvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_25030093_axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_25030093_axi_rd_arbiter
// Purpose : self-checking bench. Two arbiters (round-robin and fixed priority)
//           share every input; a transaction-level model predicts each one's
//           outputs cycle by cycle. Directed scenarios first, then random.
// ----------------------------------------------------------------------------
module tb_ysyx_25030093_axi_rd_arbiter;
  import ysyx_25030093_axi_rd_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] m0_araddr, m1_araddr, s_rdata;
  logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
  logic        s_arready, s_rvalid;
  logic [1:0]  s_rresp;

  logic [31:0] a_s_araddr, a_m0_rdata, a_m1_rdata, b_s_araddr, b_m0_rdata, b_m1_rdata;
  logic [1:0]  a_m0_rresp, a_m1_rresp, b_m0_rresp, b_m1_rresp;
  logic        a_s_arvalid, a_s_rready, a_m0_arready, a_m1_arready, a_m0_rvalid, a_m1_rvalid;
  logic        b_s_arvalid, b_s_rready, b_m0_arready, b_m1_arready, b_m0_rvalid, b_m1_rvalid;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: per instance, where its single transaction is and who owns it.
  // phase 0 = no transaction, 1 = address not yet accepted, 2 = awaiting data.
  int   ph  [2];
  logic win [2];
  logic lst [2];

  logic [9:0]  act_ctl [2];
  logic [31:0] act_adr [2];
  logic [31:0] act_rd0 [2];
  logic [31:0] act_rd1 [2];

  always #5 clock = ~clock;

  ysyx_25030093_axi_rd_arbiter #(.RR_EN(1)) dut_rr (
    .clock(clock), .reset_n(reset_n),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(a_m0_arready),
    .m0_rdata(a_m0_rdata), .m0_rresp(a_m0_rresp), .m0_rvalid(a_m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(a_m1_arready),
    .m1_rdata(a_m1_rdata), .m1_rresp(a_m1_rresp), .m1_rvalid(a_m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(a_s_araddr), .s_arvalid(a_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(a_s_rready)
  );

  ysyx_25030093_axi_rd_arbiter #(.RR_EN(0)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(b_m0_arready),
    .m0_rdata(b_m0_rdata), .m0_rresp(b_m0_rresp), .m0_rvalid(b_m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(b_m1_arready),
    .m1_rdata(b_m1_rdata), .m1_rresp(b_m1_rresp), .m1_rvalid(b_m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(b_s_araddr), .s_arvalid(b_s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(b_s_rready)
  );

  assign act_ctl[0] = {a_s_arvalid, a_s_rready, a_m0_arready, a_m1_arready,
                       a_m0_rvalid, a_m1_rvalid, a_m0_rresp, a_m1_rresp};
  assign act_ctl[1] = {b_s_arvalid, b_s_rready, b_m0_arready, b_m1_arready,
                       b_m0_rvalid, b_m1_rvalid, b_m0_rresp, b_m1_rresp};
  assign act_adr[0] = a_s_araddr;
  assign act_adr[1] = b_s_araddr;
  assign act_rd0[0] = a_m0_rdata;
  assign act_rd0[1] = b_m0_rdata;
  assign act_rd1[0] = a_m1_rdata;
  assign act_rd1[1] = b_m1_rdata;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic ar, input logic rv,
                       input logic [1:0] rs, input logic [31:0] rd, input logic r0, input logic r1);
    m0_arvalid = v0; m1_arvalid = v1; s_arready = ar; s_rvalid = rv;
    s_rresp = rs; s_rdata = rd; m0_rready = r0; m1_rready = r1;
  endtask

  // Called at a falling edge with inputs set: checks both instances against
  // the model, then advances the model across the next rising edge.
  task automatic step();
    logic [9:0]  ec;
    logic [31:0] ea, e0, e1;
    logic        arv, rr, ar0, ar1, rv0, rv1;
    logic [1:0]  rs0, rs1;
    logic        mv_rready;
    string       nm;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        ph[k]  = 0;
        lst[k] = 1'b1;
      end
      arv = 1'b0; rr = 1'b0; ar0 = 1'b0; ar1 = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
      rs0 = 2'b00; rs1 = 2'b00; ea = 32'd0; e0 = 32'd0; e1 = 32'd0;
      if (ph[k] == 1) begin
        arv = 1'b1;
        ea  = win[k] ? m1_araddr : m0_araddr;
        if (win[k]) ar1 = s_arready; else ar0 = s_arready;
      end
      if (ph[k] == 2) begin
        rr = win[k] ? m1_rready : m0_rready;
        if (win[k]) begin rv1 = s_rvalid; e1 = s_rdata; rs1 = s_rresp; end
        else        begin rv0 = s_rvalid; e0 = s_rdata; rs0 = s_rresp; end
      end
      ec = {arv, rr, ar0, ar1, rv0, rv1, rs0, rs1};
      nm = (k == 0) ? "rr" : "fp";
      check_val({nm, "_ctl"},   {22'd0, act_ctl[k]}, {22'd0, ec});
      check_val({nm, "_araddr"}, act_adr[k], ea);
      check_val({nm, "_rdata0"}, act_rd0[k], e0);
      check_val({nm, "_rdata1"}, act_rd1[k], e1);
    end
    @(posedge clock);
    cyc++;
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin
        mv_rready = win[k] ? m1_rready : m0_rready;
        if (ph[k] == 0) begin
          if (m0_arvalid || m1_arvalid) begin
            if (m0_arvalid && m1_arvalid) win[k] = (k == 0) ? !lst[k] : 1'b1;
            else                          win[k] = m1_arvalid;
            ph[k] = 1;
          end
        end else if (ph[k] == 1) begin
          if (s_arready) ph[k] = 2;
        end else begin
          if (s_rvalid && mv_rready) begin
            ph[k]  = 0;
            lst[k] = win[k];
          end
        end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    ph[0] = 0; ph[1] = 0; win[0] = 1'b0; win[1] = 1'b0; lst[0] = 1'b1; lst[1] = 1'b1;
    reset_n   = 1'b0;
    m0_araddr = 32'ha000_0048;
    m1_araddr = 32'h8000_1000;
    drive(1'b1, 1'b1, 1'b1, 1'b1, RESP_DECERR, 32'hdead_beef, 1'b1, 1'b1);
    @(negedge clock);
    step();
    step();
    reset_n = 1'b1;

    // Lone IFU fetch with an immediately responding slave.
    drive(1'b1, 1'b0, 1'b1, 1'b1, RESP_OKAY, 32'h0000_1234, 1'b1, 1'b1);
    step();
    m0_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Simultaneous requests held high: ordering differs by policy.
    drive(1'b1, 1'b1, 1'b1, 1'b1, RESP_SLVERR, 32'h0bad_0001, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, RESP_OKAY, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step();

    // Address stall while the ungranted LSU toggles arvalid.
    drive(1'b1, 1'b0, 1'b0, 1'b0, RESP_OKAY, 32'h5555_aaaa, 1'b1, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      m1_arvalid = i[0];
      m1_araddr  = 32'h1000_0000 + i;
      step();
    end
    m1_arvalid = 1'b0; m0_arvalid = 1'b0; s_arready = 1'b1; s_rvalid = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // DECERR to the LSU with a late rready.
    drive(1'b0, 1'b1, 1'b1, 1'b1, RESP_DECERR, 32'hcafe_f00d, 1'b1, 1'b0);
    step();
    m1_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    m1_rready = 1'b1;
    for (int i = 0; i < 2; i++) step();

    // Reset pulse during the data phase, then a clean fetch.
    drive(1'b1, 1'b0, 1'b1, 1'b0, RESP_OKAY, 32'h7777_0000, 1'b1, 1'b1);
    step();
    m0_arvalid = 1'b0;
    step();
    s_rvalid = 1'b1;
    reset_n  = 1'b0;
    step();
    reset_n  = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, RESP_OKAY, 32'h0000_4321, 1'b1, 1'b1);
    step();
    m0_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      m0_arvalid = ($urandom_range(0, 9) < 4);
      m1_arvalid = ($urandom_range(0, 9) < 4);
      m0_araddr  = $urandom;
      m1_araddr  = $urandom;
      s_arready  = $urandom_range(0, 1) == 1;
      s_rvalid   = $urandom_range(0, 1) == 1;
      s_rdata    = $urandom;
      s_rresp    = 2'($urandom_range(0, 3));
      m0_rready  = ($urandom_range(0, 9) < 6);
      m1_rready  = ($urandom_range(0, 9) < 6);
      reset_n    = ($urandom_range(0, 199) != 0);
      step();
    end
    reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_axi_rd_arbiter.md
YSYX_25030093_AXI_RD_ARBITER -- requirements
Module: ysyx_25030093_axi_rd_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1; 1 = round-robin on ties, 0 = fixed priority (m1 wins ties).
REQ-002 SHALL have clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have m0_araddr  input  32  IFU read address.
REQ-005 SHALL have m0_arvalid / m0_arready  in/out  1/1  IFU AR handshake.
REQ-006 SHALL have m0_rdata / m0_rresp  output  32/2  IFU read data and response.
REQ-007 SHALL have m0_rvalid / m0_rready  out/in  1/1  IFU R handshake.
REQ-008 SHALL have m1_araddr, m1_arvalid, m1_arready, m1_rdata, m1_rresp, m1_rvalid, m1_rready, with the same widths and directions as m0_*, for the LSU.
REQ-009 SHALL have s_araddr / s_arvalid  output  32/1  downstream AR toward the CLINT/SoC xbar.
REQ-010 SHALL have s_arready  input  1  downstream AR ready.
REQ-011 SHALL have s_rdata / s_rresp / s_rvalid  input  32/2/1  downstream R.
REQ-012 SHALL have s_rready  output  1  downstream R ready.
REQ-013 SHALL carry no write channels; LSU writes bypass this block.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR and DATA, with exactly one transaction outstanding.
REQ-015 In IDLE, at any edge where m0_arvalid or m1_arvalid is high, SHALL register grant g and move to ADDR.
REQ-016 Single requester SHALL be granted; on a tie with RR_EN=1, the master not in last_grant SHALL win; on a tie with RR_EN=0, m1 SHALL win.
REQ-017 In ADDR, SHALL drive s_arvalid=1 and s_araddr=mg_araddr, with mg_arready = s_arready combinationally; all other arready outputs SHALL be 0.
REQ-018 ADDR SHALL go to DATA on s_arvalid&s_arready; it SHALL wait indefinitely otherwise.
REQ-019 In DATA, SHALL route mg_rvalid=s_rvalid, mg_rdata=s_rdata, mg_rresp=s_rresp and s_rready=mg_rready; the ungranted master's rvalid SHALL be 0.
REQ-020 DATA SHALL return to IDLE on s_rvalid&s_rready, and last_grant SHALL update to g on that edge.
REQ-021 Latency: request visible at edge t SHALL produce s_arvalid in cycle t+1; there SHALL be one IDLE bubble between back-to-back transactions.
REQ-022 rresp (OKAY/SLVERR/DECERR) SHALL pass through unmodified; no retry on error.
REQ-023 A request arriving while another transaction is in flight SHALL wait; it SHALL not be dropped and SHALL not preempt.
REQ-024 Outside IDLE, changes on ungranted inputs SHALL have no effect on any output.
REQ-025 s_arvalid and m*_rvalid SHALL never be asserted in IDLE.

Reset
REQ-026 reset_n low SHALL immediately force state=IDLE and last_grant=1 (first tie goes to m0 when RR_EN=1).
REQ-027 Under reset, s_arvalid, s_rready, m*_arready and m*_rvalid SHALL be 0, and m*_rdata and m*_rresp SHALL be 0.
REQ-028 Reset mid-ADDR/DATA SHALL abandon the transaction; downstream reset is the system's responsibility.

Structure
REQ-029 Shared package SHALL hold the FSM state enum (IDLE/ADDR/DATA) and the AXI RESP constants (OKAY=0, SLVERR=2, DECERR=3).
REQ-030 Tie-break logic SHALL be one sub-module, ysyx_25030093_rr_pick (inputs: req[1:0], last, rr_en; output: grant).

Verification
REQ-031 Only m0 requests 0xa0000048 and the slave replies at once with 0x00001234: s_arvalid 1 cycle later, m0_rdata=0x00001234 with rresp=0, and m1_rvalid stays 0.
REQ-032 After reset, m0 and m1 assert in the same cycle: m0 is served first, m1 next with one IDLE bubble; on a second tie m0 wins again (last_grant=1).
REQ-033 RR_EN=0 and a simultaneous tie repeated 3 times: m1 wins every time.
REQ-034 s_arready held low 5 cycles while m1 toggles arvalid: FSM stays in ADDR, m1_arready=0, and the m0 handshake completes on cycle 6.
REQ-035 Slave returns rresp=2'b11 to m1 and m1_rready is delayed 3 cycles: m1_rresp=3 is held with rvalid high until the handshake, then IDLE.
REQ-036 reset_n pulsed low during DATA: all valids drop within the same cycle, and a fresh m0 request after reset completes normally.
